mult_job_sequencer: RTL and testbench
=====================================

// Module: mult_job_sequencer
// PURPOSE
//  Upstream sequencer for the free-running repeated-add multiplier (instantiated beside it in the parent).
//  - Accepts operand pairs on a valid/ready port and drives them, held stable, onto the multiplier.
//  - Pulses the multiplier's active-low reset to align its phase.
//  - Samples the product at a fixed, operand-dependent edge and returns it on a valid/ready result port.
// PARAMETERS
//  WIDTH_IN   8   operand width; must be >= 2
//  WIDTH_OUT  16  product width; must be >= 2*WIDTH_IN
// PORTS
//  CLK               in   1          single clock; all logic on posedge
//  RST               in   1          synchronous reset, active-high
//  in_valid          in   1          operand pair valid
//  in_ready          out  1          sequencer can accept a pair
//  in_a              in   WIDTH_IN   operand A
//  in_b              in   WIDTH_IN   operand B
//  out_valid         out  1          result valid
//  out_ready         in   1          consumer accepts result
//  out_product       out  WIDTH_OUT  A*B
//  mult_rst_n        out  1          to multiplier RST_N
//  mult_multiplicand out  WIDTH_IN   to multiplier multiplicand
//  mult_multiplier   out  WIDTH_IN   to multiplier multiplier (sets iteration count)
//  mult_product      in   WIDTH_OUT  from multiplier product
// BEHAVIOUR
//  Reset (RST=1 at an edge): state<=IDLE.
//   - Registered outputs after that edge: out_valid=0, out_product=0, mult_rst_n=0, mult_multiplicand=0, mult_multiplier=0, cnt=0.
//   - in_ready=0 while RST is high. Reset wins over every other event, including mid-job; the job is dropped.
//  States:
//   - IDLE: in_ready=1 (combinational from state); mult_rst_n=1.
//       On in_valid&&in_ready at edge E0: latch A->mult_multiplicand, B->mult_multiplier; mult_rst_n<=0; ->LAUNCH.
//   - LAUNCH: one cycle; multiplier resets at E1.
//       At E1: mult_rst_n<=1; cnt<=mult_multiplier+2; ->WAIT.
//   - WAIT: cnt decrements each edge.
//       At the edge where cnt==0 (E(M+4), M=mult_multiplier): out_product<=mult_product; out_valid<=1; ->DONE.
//   - DONE: out_valid=1, out_product held stable.
//       On out_ready at an edge: out_valid<=0; ->IDLE.
//  Handshakes:
//   - in_ready=0 in LAUNCH, WAIT and DONE; no accept in the cycle DONE is left.
//   - in_valid/in_a/in_b are ignored when in_ready=0.
//  Latency: out_valid first high M+4 cycles after the accept edge. Throughput: one job per >= M+6 cycles.
//  Multiplier phase after release:
//   - E2 loads the iteration count; E3..E(M+2) add.
//   - E(M+3) writes the product; sampling at E(M+4) is stable for all M, including M=0.
//  Operands are held constant from E0 until DONE exits.
//  Widths: cnt is WIDTH_IN+1 bits. M+2 <= 2^WIDTH_IN+1 never wraps.
//  out_product is a plain copy; no truncation when WIDTH_OUT >= 2*WIDTH_IN.
//  Back-pressure: out_ready low holds DONE indefinitely; the multiplier keeps free-running, its output is ignored.
// CONFIGURATION
//  OPERAND_SWAP_EN:
//   - Defined: at accept, the smaller of A,B goes to mult_multiplier, the larger to mult_multiplicand; ties are unswapped.
//     Latency becomes min(A,B)+4. The product is unchanged (commutative).
//   - Undefined: A->multiplicand, B->multiplier always; latency B+4.
// STRUCTURE
//  Package mult_seq_pkg:
//   - state enum {IDLE, LAUNCH, WAIT, DONE}
//   - localparam LAT_OFFSET=4
//   - localparam CNT_W(WIDTH_IN)=WIDTH_IN+1
//  No sub-module: single FSM plus counter. The multiplier is instantiated in the parent, not inside this block.
// TESTING
//  - Reset: hold RST 3 cycles -> out_valid=0, mult_rst_n=0, in_ready=0; after release in_ready=1 next cycle.
//  - A=7, B=9, out_ready=1 -> out_valid rises 13 cycles after the accept edge with out_product=63; in_ready=1 the cycle after.
//  - A=200, B=0 -> out_product=0 at latency 4; A=255, B=255 -> out_product=65025 at latency 259.
//  - A=12, B=5, out_ready low 6 cycles after out_valid -> out_product=60 held, in_valid pulses ignored; accept on out_ready.
//  - A=50, B=40, RST raised 10 cycles after accept -> IDLE, no out_valid, mult_rst_n=0; the next job 3*4 returns 12.
//  - OPERAND_SWAP_EN defined: A=3, B=200 -> out_product=600 at latency 7 (undefined: latency 204).

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the repeated-add multiplier job sequencer.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Edges from the accept edge to the product sampling edge, beyond the iteration count.
    localparam int LAT_OFFSET = 4;

    function automatic int cnt_width(input int width_in);
        return width_in + 1;
    endfunction

endpackage

// File: rtl/mult_job_sequencer.sv
// Feeds operand pairs to the free-running repeated-add multiplier, aligns its phase via
// its reset and returns the product. Optional macro OPERAND_SWAP_EN: smaller operand sets iteration count.
//
// state  | meaning
// IDLE   | ready for an operand pair, multiplier released
// LAUNCH | multiplier held in reset for one cycle
// WAIT   | counting down to the product sampling edge
// DONE   | product presented, waiting for out_ready
module mult_job_sequencer
    import mult_seq_pkg::*;
#(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_IN-1:0]  in_a,
    input  logic [WIDTH_IN-1:0]  in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_OUT-1:0] out_product,
    output logic                 mult_rst_n,
    output logic [WIDTH_IN-1:0]  mult_multiplicand,
    output logic [WIDTH_IN-1:0]  mult_multiplier,
    input  logic [WIDTH_OUT-1:0] mult_product
);

    localparam int CNT_W = cnt_width(WIDTH_IN);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH_IN-1:0] sel_multiplicand;
    logic [WIDTH_IN-1:0] sel_multiplier;

    assign in_ready = (state == ST_IDLE) && !RST;

`ifdef OPERAND_SWAP_EN
    // Smaller operand drives the iteration count; ties keep A as multiplicand.
    always_comb begin
        sel_multiplicand = in_a;
        sel_multiplier   = in_b;
        if (in_a < in_b) begin
            sel_multiplicand = in_b;
            sel_multiplier   = in_a;
        end
    end
`else
    always_comb begin
        sel_multiplicand = in_a;
        sel_multiplier   = in_b;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state             <= ST_IDLE;
            out_valid         <= 1'b0;
            out_product       <= '0;
            mult_rst_n        <= 1'b0;
            mult_multiplicand <= '0;
            mult_multiplier   <= '0;
            cnt               <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mult_rst_n <= 1'b1;
                    if (in_valid && in_ready) begin
                        mult_multiplicand <= sel_multiplicand;
                        mult_multiplier   <= sel_multiplier;
                        mult_rst_n        <= 1'b0;
                        state             <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    mult_rst_n <= 1'b1;
                    cnt        <= CNT_W'(mult_multiplier) + CNT_W'(LAT_OFFSET - 2);
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Product was written one edge earlier, so it is stable here even for M=0.
                    if (cnt == '0) begin
                        out_product <= mult_product;
                        out_valid   <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Scoreboard bench for mult_job_sequencer with a behavioural repeated-add multiplier beside it.
module tb_mult_job_sequencer;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        mult_rst_n;
    logic [7:0]  mult_multiplicand;
    logic [7:0]  mult_multiplier;
    logic [15:0] mult_product;

    mult_job_sequencer #(.WIDTH_IN(8), .WIDTH_OUT(16)) dut (
        .CLK(CLK),
        .RST(RST),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_product(out_product),
        .mult_rst_n(mult_rst_n),
        .mult_multiplicand(mult_multiplicand),
        .mult_multiplier(mult_multiplier),
        .mult_product(mult_product)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Free-running multiplier: reset, load count, add M times, write product, repeat.
    logic [15:0] m_acc;
    logic [7:0]  m_cnt;
    logic        m_load;
    initial begin
        mult_product = 16'd0;
        m_acc        = 16'd0;
        m_cnt        = 8'd0;
        m_load       = 1'b1;
    end
    always @(posedge CLK) begin
        if (!mult_rst_n) begin
            m_load <= 1'b1;
            m_acc  <= 16'd0;
        end else if (m_load) begin
            m_cnt  <= mult_multiplier;
            m_acc  <= 16'd0;
            m_load <= 1'b0;
        end else if (m_cnt != 8'd0) begin
            m_acc <= m_acc + 16'(mult_multiplicand);
            m_cnt <= m_cnt - 8'd1;
        end else begin
            mult_product <= m_acc;
            m_load       <= 1'b1;
        end
    end

    typedef struct {
        int product;
        int lat;
        int acc_edge;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare on each rising out_valid.
    logic prev_valid = 1'b0;
    always @(negedge CLK) begin
        if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", out_product, e.product);
                check("latency", cyc - e.acc_edge, e.lat);
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input int a, input int b, input int prod, input int lat, input bit push);
        int n;
        exp_t e;
        @(negedge CLK);
        in_a     = 8'(a);
        in_b     = 8'(b);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) check("accept_timeout", 0, 1);
        e.product  = prod;
        e.lat      = lat;
        e.acc_edge = cyc + 1;
        if (push) sb.push_back(e);
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) check("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(in_ready && !out_valid && sb.size() == 0) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) check("job_done_timeout", 0, 1);
    endtask

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        out_ready = 1'b1;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_out_valid", out_valid, 0);
        check("rst_mult_rst_n", mult_rst_n, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_product", out_product, 0);
        check("rst_mult_multiplier", mult_multiplier, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_mult_rst_n", mult_rst_n, 1);

`ifdef OPERAND_SWAP_EN
        send(7, 9, 63, 11, 1'b1);
`else
        send(7, 9, 63, 13, 1'b1);
`endif
        wait_out();
        @(negedge CLK);
        check("in_ready_after_done", in_ready, 1);
        check("out_valid_dropped", out_valid, 0);

        send(200, 0, 0, 4, 1'b1);
        wait_done();
        send(255, 255, 65025, 259, 1'b1);
        wait_done();

        out_ready = 1'b0;
        send(12, 5, 60, 9, 1'b1);
        wait_out();
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            in_a     = 8'd1;
            in_b     = 8'd1;
            @(negedge CLK);
            check("bp_product_held", out_product, 60);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        check("bp_release", out_valid, 0);
        wait_done();

        send(50, 40, 2000, 44, 1'b0);
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("midjob_rst_out_valid", out_valid, 0);
        check("midjob_rst_mult_rst_n", mult_rst_n, 0);
        check("midjob_rst_in_ready", in_ready, 0);
        RST = 1'b0;
        repeat (60) @(negedge CLK);
        check("midjob_no_result", out_valid, 0);
`ifdef OPERAND_SWAP_EN
        send(3, 4, 12, 7, 1'b1);
`else
        send(3, 4, 12, 8, 1'b1);
`endif
        wait_done();

`ifdef OPERAND_SWAP_EN
        send(3, 200, 600, 7, 1'b1);
`else
        send(3, 200, 600, 204, 1'b1);
`endif
        wait_done();

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
